voice_allocator: RTL

// Upstream of the per-voice ADSR envelopes: turns a stream of note-on/note-off events into per-voice

---
 rtl/voice_allocator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Voice allocator: turns note-on/off events into per-voice gate/note/velocity for ADSR-driven voices.
// Optional feature: define VOICE_STEAL_EN to steal the oldest held voice instead of dropping the note-on.
module voice_allocator #(
  parameter int VOICES    = 4,
  parameter int NOTE_BITS = 7,
  parameter int VEL_BITS  = 7,
  parameter int AGE_BITS  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_BITS-1:0]          ev_note,
  input  logic [VEL_BITS-1:0]           ev_velocity,
  input  logic [VOICES-1:0]             active,
  output logic [VOICES-1:0]             gate,
  output logic [VOICES*NOTE_BITS-1:0]   note,
  output logic [VOICES*VEL_BITS-1:0]    velocity,
  output logic                          dropped
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [1:0] {IDLE, DECIDE, RETRIG} state_t;

  state_t               state, state_next;
  logic                 ev_on_q;
  logic [NOTE_BITS-1:0] ev_note_q;
  logic [VEL_BITS-1:0]  ev_vel_q;
  logic [AGE_BITS-1:0]  age [VOICES];
  logic [IDX_W-1:0]     retrig_idx;

  logic                 hit_found, free_found, rel_found;
  logic [IDX_W-1:0]     hit_idx, free_idx, rel_idx;
  logic [AGE_BITS-1:0]  rel_age;
  logic [VOICES-1:0]    off_mask;
  logic                 alloc_drop, alloc_retrig;
  logic [IDX_W-1:0]     alloc_idx;
`ifdef VOICE_STEAL_EN
  logic                 held_found;
  logic [IDX_W-1:0]     held_idx;
  logic [AGE_BITS-1:0]  held_age;
`endif

  assign ev_ready = (state == IDLE) && !reset;

  // Candidate search over all voices; strict '>' keeps the lowest index on age ties.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rel_found  = 1'b0;
    rel_idx    = '0;
    rel_age    = '0;
    off_mask   = '0;
`ifdef VOICE_STEAL_EN
    held_found = 1'b0;
    held_idx   = '0;
    held_age   = '0;
`endif
    for (int unsigned i = 0; i < VOICES; i++) begin
      if (gate[i] && (note[i*NOTE_BITS +: NOTE_BITS] == ev_note_q)) begin
        off_mask[i] = 1'b1;
        if (!hit_found) begin
          hit_found = 1'b1;
          hit_idx   = IDX_W'(i);
        end
      end
      if (!gate[i] && !active[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!gate[i] && active[i] && (!rel_found || (age[i] > rel_age))) begin
        rel_found = 1'b1;
        rel_idx   = IDX_W'(i);
        rel_age   = age[i];
      end
`ifdef VOICE_STEAL_EN
      if (gate[i] && (!held_found || (age[i] > held_age))) begin
        held_found = 1'b1;
        held_idx   = IDX_W'(i);
        held_age   = age[i];
      end
`endif
    end
  end

  always_comb begin
    alloc_drop   = 1'b0;
    alloc_retrig = 1'b0;
    alloc_idx    = '0;
    if (hit_found) begin
      alloc_idx    = hit_idx;
      alloc_retrig = 1'b1;
    end else if (free_found) begin
      alloc_idx = free_idx;
    end else if (rel_found) begin
      alloc_idx = rel_idx;
    end else begin
`ifdef VOICE_STEAL_EN
      alloc_idx    = held_idx;
      alloc_retrig = 1'b1;
`else
      alloc_drop   = 1'b1;
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ev_valid) state_next = DECIDE;
      DECIDE:  state_next = (ev_on_q && alloc_retrig) ? RETRIG : IDLE;
      RETRIG:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_vel_q   <= '0;
      retrig_idx <= '0;
      gate       <= '0;
      note       <= '0;
      velocity   <= '0;
      dropped    <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) age[i] <= '0;
    end else begin
      state   <= state_next;
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid) begin
            ev_on_q   <= ev_on;
            ev_note_q <= ev_note;
            ev_vel_q  <= ev_velocity;
          end
        end
        DECIDE: begin
          if (!ev_on_q) begin
            gate <= gate & ~off_mask;
          end else if (alloc_drop) begin
            dropped <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < VOICES; i++)
              if (age[i] != '1) age[i] <= age[i] + 1'b1;
            age[alloc_idx]                           <= '0;
            note[alloc_idx*NOTE_BITS +: NOTE_BITS]   <= ev_note_q;
            velocity[alloc_idx*VEL_BITS +: VEL_BITS] <= ev_vel_q;
            gate[alloc_idx]                          <= !alloc_retrig;
            retrig_idx                               <= alloc_idx;
          end
        end
        RETRIG: gate[retrig_idx] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
